// File: rtl/exec_unit.sv
// Multi-cycle 8-bit execution unit: fetches operands from an external register
// file, executes one ALU operation and writes the result back.
module exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  rf_addr,
    output logic        rf_rd,
    output logic        rf_wr,
    output logic [7:0]  rf_wdata,
    input  logic [7:0]  rf_rdata,
    output logic        done,
    output logic        illegal,
    output logic        zero_flag,
    output logic        carry_flag
);

    typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXE, S_WB} state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2,
                           OP_AND = 4'h3, OP_OR  = 4'h4, OP_XOR = 4'h5,
                           OP_NOT = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8,
                           OP_MOV = 4'h9, OP_LDI = 4'hA;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic        zero_q, zero_d, carry_q, carry_d;

    logic [3:0]  op;
    logic        is_wb_op, is_illegal, needs_read, accept;
    logic [7:0]  alu_res;
    logic        alu_c;

    assign op         = instr_q[15:12];
    assign is_wb_op   = (op != OP_NOP) && (op <= OP_LDI);
    assign is_illegal = (op > OP_LDI);
    assign needs_read = is_wb_op && (op != OP_LDI);
    assign accept     = (state_q == S_IDLE) && instr_valid;

    // B is live on rf_rdata during EXE; b_q only holds it afterwards.
    assign b_d = (state_q == S_EXE) ? rf_rdata : b_q;

    always_comb begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
        case (op)
            OP_ADD:  {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_d};
            OP_SUB:  {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_d};
            OP_AND:  alu_res = a_q & b_d;
            OP_OR:   alu_res = a_q | b_d;
            OP_XOR:  alu_res = a_q ^ b_d;
            OP_NOT:  alu_res = ~a_q;
            OP_SHL:  {alu_c, alu_res} = {a_q, 1'b0};
            OP_SHR:  {alu_res, alu_c} = {1'b0, a_q};
            OP_MOV:  alu_res = a_q;
            OP_LDI:  alu_res = instr_q[7:0];
            default: alu_res = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= 16'h0000;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            res_q   <= 8'h00;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        instr_d = accept ? instr : instr_q;
        a_d     = (state_q == S_RDB) ? rf_rdata : a_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        if (state_q == S_EXE && is_wb_op) begin
            res_d   = alu_res;
            zero_d  = (alu_res == 8'h00);
            carry_d = alu_c;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if ((instr[15:12] != OP_NOP) && (instr[15:12] < OP_LDI))
                        state_d = S_RDA;
                    else
                        state_d = S_EXE;
                end
            end
            S_RDA:   state_d = S_RDB;
            S_RDB:   state_d = S_EXE;
            S_EXE:   state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE);
        rf_rd       = 1'b0;
        rf_wr       = 1'b0;
        rf_addr     = 3'd0;
        rf_wdata    = 8'h00;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_RDA: begin
                rf_rd   = needs_read;
                rf_addr = instr_q[8:6];
            end
            S_RDB: begin
                rf_rd   = needs_read;
                rf_addr = instr_q[5:3];
            end
            S_WB: begin
                done    = 1'b1;
                illegal = is_illegal;
                if (is_wb_op) begin
                    rf_wr    = 1'b1;
                    rf_addr  = instr_q[11:9];
                    rf_wdata = res_q;
                end
            end
            default: ;
        endcase
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit with a behavioural register file.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  rf_addr;
    logic        rf_rd, rf_wr;
    logic [7:0]  rf_wdata;
    logic [7:0]  rf_rdata = 8'h00;
    logic        done, illegal, zero_flag, carry_flag;

    logic [7:0]  mem [8] = '{default: 8'h00};
    logic        both_seen = 1'b0;
    int          total = 0;
    int          bad = 0;

    exec_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rf_addr(rf_addr), .rf_rd(rf_rd),
        .rf_wr(rf_wr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .done(done), .illegal(illegal), .zero_flag(zero_flag),
        .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    // Register file: synchronous read, data valid the cycle after rf_rd.
    always @(posedge clk) begin
        if (rf_wr) mem[rf_addr] <= rf_wdata;
        if (rf_rd) rf_rdata <= mem[rf_addr];
    end

    always @(negedge clk) if (rf_rd && rf_wr) both_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] d,
                                       input logic [2:0] s1, input logic [2:0] s2);
        return {op, d, s1, s2, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
        return {4'hA, d, 1'b0, imm};
    endfunction

    // Issue one instruction from IDLE and check its retirement cycle.
    task automatic run(input string tag, input logic [15:0] ins, input int lat,
                       input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                       input logic z, input logic c, input logic ill);
        int n;
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_wr"}, rf_wr, wr);
        if (wr) begin
            chk({tag, "_addr"}, rf_addr, addr);
            chk({tag, "_wdata"}, rf_wdata, wdata);
        end
        chk({tag, "_zero"}, zero_flag, z);
        chk({tag, "_carry"}, carry_flag, c);
        chk({tag, "_illegal"}, illegal, ill);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, instr_ready, 1'b1);
    endtask

    initial begin
        int t, acc[3], wait_n, seen_bad;
        rst = 1'b1;
        instr = 16'h0000;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rfwr", rf_wr, 1'b0);
        chk("rst_addr", rf_addr, 3'd0);
        chk("rst_flags", {zero_flag, carry_flag, done, illegal, rf_rd}, 5'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1'b1);

        run("ldi1", ldi(3'd1, 8'hF0), 2, 1, 3'd1, 8'hF0, 0, 0, 0);
        run("ldi2", ldi(3'd2, 8'h20), 2, 1, 3'd2, 8'h20, 0, 0, 0);
        run("add",  mk(4'h1, 3'd3, 3'd1, 3'd2), 4, 1, 3'd3, 8'h10, 0, 1, 0);
        chk("add_mem", mem[3], 8'h10);
        run("sub",  mk(4'h2, 3'd4, 3'd2, 3'd1), 4, 1, 3'd4, 8'h30, 0, 1, 0);
        run("subz", mk(4'h2, 3'd5, 3'd1, 3'd1), 4, 1, 3'd5, 8'h00, 1, 0, 0);
        run("nop",  16'h0000, 2, 0, 3'd0, 8'h00, 1, 0, 0);
        run("ldi81", ldi(3'd1, 8'h81), 2, 1, 3'd1, 8'h81, 0, 0, 0);
        run("shl",  mk(4'h7, 3'd6, 3'd1, 3'd0), 4, 1, 3'd6, 8'h02, 0, 1, 0);
        run("shr",  mk(4'h8, 3'd6, 3'd1, 3'd0), 4, 1, 3'd6, 8'h40, 0, 1, 0);
        run("ill",  mk(4'hC, 3'd7, 3'd1, 3'd2), 2, 0, 3'd0, 8'h00, 0, 1, 1);
        run("and",  mk(4'h3, 3'd7, 3'd1, 3'd2), 4, 1, 3'd7, 8'h00, 1, 0, 0);
        run("xor",  mk(4'h5, 3'd7, 3'd1, 3'd2), 4, 1, 3'd7, 8'hA1, 0, 0, 0);
        run("movsame", mk(4'h6, 3'd2, 3'd2, 3'd2), 4, 1, 3'd2, 8'hDF, 0, 0, 0);

        // Reset while ADD r0,r1,r2 is in RDB.
        instr = mk(4'h1, 3'd0, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_ready", instr_ready, 1'b1);
        chk("mid_outs", {rf_rd, rf_wr, done, illegal, zero_flag, carry_flag}, 6'b0);
        chk("mid_addr", {rf_addr, rf_wdata}, 11'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rel_ready", instr_ready, 1'b1);
        seen_bad = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || rf_wr) seen_bad = 1;
        end
        chk("mid_nodone", seen_bad, 0);
        chk("mid_mem0", mem[0], 8'h00);

        // Back-to-back LDIs with instr_valid held high.
        instr_valid = 1'b1;
        t = 0;
        for (int k = 0; k < 3; k++) begin
            wait_n = 0;
            while (!instr_ready && wait_n < 10) begin
                @(posedge clk);
                #1;
                t++;
                wait_n++;
            end
            chk("b2b_wait", wait_n < 10, 1'b1);
            instr = ldi(3'(k + 1), 8'(8'h11 * (k + 1)));
            @(posedge clk);
            acc[k] = t;
            #1;
            t++;
        end
        instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_gap1", acc[1] - acc[0], 3);
        chk("b2b_gap2", acc[2] - acc[1], 3);
        chk("b2b_r1", mem[1], 8'h11);
        chk("b2b_r2", mem[2], 8'h22);
        chk("b2b_r3", mem[3], 8'h33);
        chk("rdwr_excl", both_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
